dcache_flush_seq: RTL and testbench

- Downstream consumer of the flush controller's `flush_dcache_o` / `flush_dcache_ack_i` pair; walks every set of the write-back DCache.
- For each set: reads per-way valid/dirty state, writes back each dirty way through the miss/writeback unit, then invalidates the set.
- Returns a single-cycle acknowledge when the whole cache is clean and invalid, which releases the fence halt.
- Arbitrates for the tag array and writeback port with req/gnt handshakes, alongside the normal miss path.

---
 rtl/dcache_flush_seq_if.sv | 62 ++++++
 rtl/dcache_flush_seq.sv | 161 ++++++++++++++++
 tb/tb_dcache_flush_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_flush_seq_if.sv
// ============================================================================
// Module      : dcache_flush_seq_if
// Description : Tag/state-array and writeback handshake bundle between the
//               DCache flush sequencer (master) and the cache arrays / miss
//               unit arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_flush_seq_if #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    // Tag/state array port
    logic                tag_req_o;
    logic                tag_we_o;
    logic [SET_W-1:0]    tag_set_o;
    logic                tag_gnt_i;
    logic [NUM_WAYS-1:0] valid_i;
    logic [NUM_WAYS-1:0] dirty_i;

    // Writeback port
    logic                wb_req_o;
    logic [SET_W-1:0]    wb_set_o;
    logic [WAY_W-1:0]    wb_way_o;
    logic                wb_gnt_i;
    logic                wb_done_i;

    modport master (
        output tag_req_o,
        output tag_we_o,
        output tag_set_o,
        input  tag_gnt_i,
        input  valid_i,
        input  dirty_i,
        output wb_req_o,
        output wb_set_o,
        output wb_way_o,
        input  wb_gnt_i,
        input  wb_done_i
    );

    modport slave (
        input  tag_req_o,
        input  tag_we_o,
        input  tag_set_o,
        output tag_gnt_i,
        output valid_i,
        output dirty_i,
        input  wb_req_o,
        input  wb_set_o,
        input  wb_way_o,
        output wb_gnt_i,
        output wb_done_i
    );

endinterface

`default_nettype wire

// File: rtl/dcache_flush_seq.sv
// ============================================================================
// Module      : dcache_flush_seq
// Description : Walks every set of the write-back DCache on a flush request,
//               writes back valid+dirty ways, invalidates each set and pulses
//               a one-cycle acknowledge when the whole cache is clean.
//               Optional writeback counter: define DCACHE_FLUSH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_flush_seq #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    input  wire logic           flush_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    dcache_flush_seq_if.master  bus
`ifdef DCACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]         flushed_lines_o
`endif
);

    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_RD    = 4'd1;
    localparam logic [3:0] c_ST_RW    = 4'd2;
    localparam logic [3:0] c_ST_SCAN  = 4'd3;
    localparam logic [3:0] c_ST_WB    = 4'd4;
    localparam logic [3:0] c_ST_WBW   = 4'd5;
    localparam logic [3:0] c_ST_INV   = 4'd6;
    localparam logic [3:0] c_ST_DONE  = 4'd7;
    localparam logic [3:0] c_ST_DRAIN = 4'd8;

    localparam logic [SET_W-1:0]    c_LAST_SET = SET_W'(NUM_SETS - 1);
    localparam logic [NUM_WAYS-1:0] c_WAY_ONE  = NUM_WAYS'(1);

    logic [3:0]          r_state;
    logic [SET_W-1:0]    r_set;
    logic [NUM_WAYS-1:0] r_mask;
    logic [WAY_W-1:0]    r_way;

    logic [WAY_W-1:0]    w_pick_way;
    logic                w_mask_nz;
    logic                w_last_set;

    // Lowest pending way wins so writebacks go out in ascending way order.
    always_comb begin
        w_pick_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_pick_way = WAY_W'(i);
            end
        end
    end

    assign w_mask_nz  = |r_mask;
    assign w_last_set = (r_set == c_LAST_SET);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_set   <= '0;
            r_mask  <= '0;
            r_way   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (flush_i) begin
                        r_state <= c_ST_RD;
                    end
                end
                c_ST_RD: begin
                    if (bus.tag_gnt_i) begin
                        r_state <= c_ST_RW;
                    end
                end
                c_ST_RW: begin
                    r_mask  <= bus.valid_i & bus.dirty_i;
                    r_state <= c_ST_SCAN;
                end
                c_ST_SCAN: begin
                    if (w_mask_nz) begin
                        r_way   <= w_pick_way;
                        r_state <= c_ST_WB;
                    end else begin
                        r_state <= c_ST_INV;
                    end
                end
                c_ST_WB: begin
                    if (bus.wb_gnt_i) begin
                        r_state <= c_ST_WBW;
                    end
                end
                c_ST_WBW: begin
                    if (bus.wb_done_i) begin
                        r_mask  <= r_mask & ~(c_WAY_ONE << r_way);
                        r_state <= c_ST_SCAN;
                    end
                end
                c_ST_INV: begin
                    if (bus.tag_gnt_i) begin
                        if (w_last_set) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_set   <= r_set + SET_W'(1);
                            r_state <= c_ST_RD;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_set   <= '0;
                    r_state <= c_ST_DRAIN;
                end
                // The controller's registered flush lags the ack by a cycle;
                // holding here keeps that stale level from starting a new walk.
                c_ST_DRAIN: begin
                    if (!flush_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tag_req_o = (r_state == c_ST_RD) || (r_state == c_ST_INV);
    assign bus.tag_we_o  = (r_state == c_ST_INV);
    assign bus.tag_set_o = r_set;
    assign bus.wb_req_o  = (r_state == c_ST_WB);
    assign bus.wb_set_o  = r_set;
    assign bus.wb_way_o  = r_way;

    assign flush_ack_o = (r_state == c_ST_DONE);
    assign busy_o      = (r_state != c_ST_IDLE) && (r_state != c_ST_DRAIN);

`ifdef DCACHE_FLUSH_PERF_EN
    logic [31:0] r_flushed_lines;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flushed_lines <= '0;
        end else if ((r_state == c_ST_IDLE) && flush_i) begin
            r_flushed_lines <= '0;
        end else if ((r_state == c_ST_WB) && bus.wb_gnt_i && (r_flushed_lines != 32'hFFFF_FFFF)) begin
            r_flushed_lines <= r_flushed_lines + 32'd1;
        end
    end

    assign flushed_lines_o = r_flushed_lines;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_flush_seq.sv
// ============================================================================
// Module      : tb_dcache_flush_seq
// Description : Directed self-checking bench for dcache_flush_seq with
//               NUM_SETS=4, NUM_WAYS=2 (perf counter checked when
//               DCACHE_FLUSH_PERF_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_flush_seq;

    localparam int c_MAX_CYC = 200;

    logic clk;
    logic rst;
    logic flush;
    logic ack;
    logic busy;
`ifdef DCACHE_FLUSH_PERF_EN
    logic [31:0] flines;
`endif

    int n_tests;
    int n_fail;

    logic [63:0] ev_log;
    logic [15:0] wb_log;
    int          n_wb;
    logic        busy_c1;
    logic [1:0]  vtab [0:3];
    logic [1:0]  dtab [0:3];
    int          ack_cyc;

    dcache_flush_seq_if #(.NUM_SETS(4), .NUM_WAYS(2)) bus ();

    dcache_flush_seq #(
        .NUM_SETS (4),
        .NUM_WAYS (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .flush_ack_o     (ack),
        .busy_o          (busy),
        .bus             (bus)
`ifdef DCACHE_FLUSH_PERF_EN
        ,
        .flushed_lines_o (flines)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {6'b0, ack, busy, bus.tag_req_o, bus.tag_we_o, bus.tag_set_o,
                bus.wb_req_o, bus.wb_set_o, bus.wb_way_o};
    endfunction

    task automatic clear_tabs();
        for (int i = 0; i < 4; i++) begin
            vtab[i] = 2'b00;
            dtab[i] = 2'b00;
        end
    endtask

    // One flush walk; inputs change and outputs are sampled on the falling edge.
    // Cycle 0 is the cycle in which flush is raised.
    task automatic run_walk(input int stall_set, input int done_dly, input int abort_set,
                            output int ack_c);
        int pend;
        int stall;
        bit stall_used;
        bit abort_arm;
        bit abort_rst;
        pend = 0; stall = 0; stall_used = 0; abort_arm = 0; abort_rst = 0;
        ack_c = -1; ev_log = '0; wb_log = '0; n_wb = 0; busy_c1 = 1'b0;
        flush = 1'b1;
        for (int cyc = 1; cyc <= c_MAX_CYC; cyc++) begin
            @(negedge clk);
            if (abort_rst) begin
                chk("abort_outs", outs(), 16'h0);
                rst = 1'b0;
                flush = 1'b0;
                ack_c = -2;
                break;
            end
            if (abort_arm) begin
                rst = 1'b1;
                abort_arm = 0;
                abort_rst = 1;
                continue;
            end
            if (cyc == 1) busy_c1 = busy;
            if (pend > 0) begin
                pend--;
                bus.wb_done_i = (pend == 0);
            end else begin
                bus.wb_done_i = 1'b0;
            end
            if (bus.tag_req_o && !bus.tag_we_o && !stall_used && int'(bus.tag_set_o) == stall_set) begin
                stall = 5;
                stall_used = 1;
            end
            if (stall > 0) begin
                chk("stall_req", 64'(bus.tag_req_o), 64'd1);
                chk("stall_set", 64'(bus.tag_set_o), 64'(stall_set));
                stall--;
                bus.tag_gnt_i = 1'b0;
            end else begin
                bus.tag_gnt_i = 1'b1;
            end
            if (bus.tag_req_o && bus.tag_gnt_i) begin
                if (bus.tag_we_o) begin
                    ev_log = {ev_log[59:0], 2'b01, bus.tag_set_o};
                end else begin
                    ev_log = {ev_log[59:0], 2'b00, bus.tag_set_o};
                    bus.valid_i = vtab[bus.tag_set_o];
                    bus.dirty_i = dtab[bus.tag_set_o];
                end
            end
            bus.wb_gnt_i = 1'b1;
            if (bus.wb_req_o) begin
                ev_log = {ev_log[59:0], 3'b100, bus.wb_way_o};
                wb_log = {wb_log[11:0], 1'b0, bus.wb_set_o, bus.wb_way_o};
                n_wb++;
                pend = done_dly;
                if (int'(bus.wb_set_o) == abort_set) abort_arm = 1;
            end
            if (ack) begin
                ack_c = cyc;
                chk("ack_busy", 64'(busy), 64'd1);
                break;
            end
        end
        if (ack_c > 0) begin
            @(negedge clk);
            chk("ack_pulse", 64'(ack), 64'd0);
            chk("drain_busy", 64'(busy), 64'd0);
            @(negedge clk);
            chk("drain_req", 64'(bus.tag_req_o), 64'd0);
            flush = 1'b0;
            @(negedge clk);
            chk("idle_req", 64'(bus.tag_req_o), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end else if (ack_c == -1) begin
            flush = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        bus.wb_done_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        flush = 1'b0;
        bus.tag_gnt_i = 1'b1;
        bus.wb_gnt_i  = 1'b1;
        bus.wb_done_i = 1'b0;
        bus.valid_i   = 2'b00;
        bus.dirty_i   = 2'b00;
        clear_tabs();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 16'h0);

        // Clean cache: R0 I0 R1 I1 R2 I2 R3 I3, ack in cycle 17
        run_walk(-1, 3, -1, ack_cyc);
        chk("clean_ack_cyc", 64'(ack_cyc), 64'd17);
        chk("clean_events", ev_log, 64'h0415_2637);
        chk("clean_no_wb", 64'(n_wb), 64'd0);
        chk("clean_busy_c1", 64'(busy_c1), 64'd1);

        // Set 2 fully dirty, wb_done 3 cycles after each grant: +10 cycles
        clear_tabs();
        vtab[2] = 2'b11;
        dtab[2] = 2'b11;
        run_walk(-1, 3, -1, ack_cyc);
        chk("dirty_ack_cyc", 64'(ack_cyc), 64'd27);
        chk("dirty_events", ev_log, 64'h04_1528_9637);
        chk("dirty_wb_list", 64'(wb_log), 64'h45);
`ifdef DCACHE_FLUSH_PERF_EN
        chk("perf_two", 64'(flines), 64'd2);
`endif

        // Dirty but invalid way is not written back
        clear_tabs();
        dtab[1] = 2'b01;
        run_walk(-1, 3, -1, ack_cyc);
        chk("inv_dirty_ack", 64'(ack_cyc), 64'd17);
        chk("inv_dirty_no_wb", 64'(n_wb), 64'd0);
`ifdef DCACHE_FLUSH_PERF_EN
        chk("perf_cleared", 64'(flines), 64'd0);
`endif

        // Tag grant withheld 5 cycles during read of set 1
        clear_tabs();
        run_walk(1, 3, -1, ack_cyc);
        chk("stall_ack_cyc", 64'(ack_cyc), 64'd22);
        chk("stall_events", ev_log, 64'h0415_2637);

        // Reset during writeback wait of set 1, then a fresh walk
        clear_tabs();
        vtab[1] = 2'b11;
        dtab[1] = 2'b11;
        run_walk(-1, 60, 1, ack_cyc);
        chk("abort_no_ack", 64'(ack_cyc), 64'hFFFF_FFFF_FFFF_FFFE);
        repeat (2) begin
            @(negedge clk);
            chk("abort_idle", outs(), 16'h0);
        end
        clear_tabs();
        run_walk(-1, 3, -1, ack_cyc);
        chk("restart_ack_cyc", 64'(ack_cyc), 64'd17);
        chk("restart_events", ev_log, 64'h0415_2637);

        // Back-to-back requests separated by a short low gap
        run_walk(-1, 3, -1, ack_cyc);
        chk("b2b_first_ack", 64'(ack_cyc), 64'd17);
        repeat (2) @(negedge clk);
        run_walk(-1, 3, -1, ack_cyc);
        chk("b2b_second_ack", 64'(ack_cyc), 64'd17);
        chk("b2b_second_events", ev_log, 64'h0415_2637);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
